pair_link_monitor: RTL and testbench

//  Consumes the four single-ended TIA-568B leg levels (12, 36, 54, 78) produced by the PostLNA

---
 rtl/pair_link_monitor_pkg.sv | 14 +
 rtl/pair_link_monitor_if.sv | 32 +++
 rtl/pair_link_monitor_pair_pulse_fsm.sv | 146 ++++++++++++++
 rtl/pair_link_monitor.sv | 77 +++++++
 tb/tb_pair_link_monitor.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pair_link_monitor_pkg.sv
// Shared types and constants for the pair-set link monitor.
// Holds the per-pair FSM state encoding and the pulse counter width.
package pair_link_monitor_pkg;

    typedef enum logic [1:0] {
        LINK_DOWN   = 2'd0,
        LINK_ARMING = 2'd1,
        LINK_UP     = 2'd2,
        LINK_FAULT  = 2'd3
    } link_state_e;

    localparam int PULSE_COUNT_W = 8;

endpackage

// File: rtl/pair_link_monitor_if.sv
// Leg inputs and status outputs of the link monitor, bundled as one interface.
// The master side drives the legs; the slave side (the monitor) reports status.
interface pair_link_monitor_if;
    import pair_link_monitor_pkg::*;

    logic                     TIA_568B12;
    logic                     TIA_568B36;
    logic                     TIA_568B54;
    logic                     TIA_568B78;
    logic                     LinkUp1236;
    logic                     LinkUp5478;
    logic                     LinkUp;
    logic [PULSE_COUNT_W-1:0] PulseCount1236;
    logic [PULSE_COUNT_W-1:0] PulseCount5478;
    logic                     PairFault1236;
    logic                     PairFault5478;

    modport master (
        output TIA_568B12, TIA_568B36, TIA_568B54, TIA_568B78,
        input  LinkUp1236, LinkUp5478, LinkUp,
        input  PulseCount1236, PulseCount5478,
        input  PairFault1236, PairFault5478
    );

    modport slave (
        input  TIA_568B12, TIA_568B36, TIA_568B54, TIA_568B78,
        output LinkUp1236, LinkUp5478, LinkUp,
        output PulseCount1236, PulseCount5478,
        output PairFault1236, PairFault5478
    );

endinterface

// File: rtl/pair_link_monitor_pair_pulse_fsm.sv
// One pair-set: leg synchronisers, pulse width qualification, gap timer,
// common-mode fault detection, link FSM and valid pulse counter.
module pair_pulse_fsm
    import pair_link_monitor_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int PULSE_MIN    = 8,
    parameter int PULSE_MAX    = 24,
    parameter int GAP_MAX      = 1600000,
    parameter int LINK_PULSES  = 3,
    parameter int FAULT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     leg_a,
    input  logic                     leg_b,
    output logic                     link_up,
    output logic [PULSE_COUNT_W-1:0] pulse_count,
    output logic                     pair_fault
);

    localparam int WIDTH_W = $clog2(PULSE_MAX + 2);
    localparam int GAP_W   = $clog2(GAP_MAX + 1);
    localparam int FLT_W   = $clog2(FAULT_CYCLES + 1);
    localparam int ARM_W   = $clog2(LINK_PULSES + 1);

    localparam logic [WIDTH_W-1:0] WIDTH_SAT  = WIDTH_W'(PULSE_MAX + 1);
    localparam logic [WIDTH_W-1:0] WIDTH_MIN  = WIDTH_W'(PULSE_MIN);
    localparam logic [WIDTH_W-1:0] WIDTH_MAX  = WIDTH_W'(PULSE_MAX);
    localparam logic [GAP_W-1:0]   GAP_LIM    = GAP_W'(GAP_MAX);
    localparam logic [FLT_W-1:0]   FLT_LAST   = FLT_W'(FAULT_CYCLES - 1);
    localparam logic [ARM_W-1:0]   ARM_TARGET = ARM_W'(LINK_PULSES);

    logic [SYNC_STAGES-1:0]   sync_a_q, sync_a_d;
    logic [SYNC_STAGES-1:0]   sync_b_q, sync_b_d;
    logic [WIDTH_W-1:0]       width_q, width_d;
    logic [GAP_W-1:0]         gap_q, gap_d;
    logic [FLT_W-1:0]         flt_q, flt_d;
    logic [ARM_W-1:0]         arm_q, arm_d;
    logic [PULSE_COUNT_W-1:0] count_q, count_d;
    link_state_e              state_q, state_d;
    logic                     link_up_q, link_up_d;
    logic                     fault_q, fault_d;

    logic diff, cm, idle, fall, valid, invalid, expiry;
    logic fault_cond, fault_hit, pulse_taken;

    always_comb begin
        sync_a_d    = {sync_a_q[SYNC_STAGES-2:0], leg_a};
        sync_b_d    = {sync_b_q[SYNC_STAGES-2:0], leg_b};
        diff        = sync_a_q[SYNC_STAGES-1] & ~sync_b_q[SYNC_STAGES-1];
        cm          = sync_a_q[SYNC_STAGES-1] &  sync_b_q[SYNC_STAGES-1];
        idle        = ~sync_a_q[SYNC_STAGES-1] & ~sync_b_q[SYNC_STAGES-1];

        width_d     = '0;
        if (diff) begin
            width_d = (width_q == WIDTH_SAT) ? width_q : width_q + 1'b1;
        end

        // The width counter is only non-zero while diff was high, so it doubles as the falling-edge detector.
        fall        = ~diff && (width_q != '0);
        valid       = fall && (width_q >= WIDTH_MIN) && (width_q <= WIDTH_MAX);
        invalid     = fall && !valid;
        expiry      = (gap_q == GAP_LIM);

        // Outside FAULT we count common-mode cycles; inside FAULT we count cycles with both legs low.
        fault_cond  = (state_q == LINK_FAULT) ? idle : cm;
        fault_hit   = fault_cond && (flt_q == FLT_LAST);
        flt_d       = (fault_cond && !fault_hit) ? flt_q + 1'b1 : '0;

        pulse_taken = valid && (state_q != LINK_FAULT) && !fault_hit;

        state_d     = state_q;
        arm_d       = arm_q;
        count_d     = pulse_taken ? count_q + 1'b1 : count_q;
        gap_d       = pulse_taken ? '0 : (expiry ? gap_q : gap_q + 1'b1);

        if (fault_hit) begin
            state_d = (state_q == LINK_FAULT) ? LINK_DOWN : LINK_FAULT;
            arm_d   = '0;
        end else begin
            case (state_q)
                LINK_DOWN: begin
                    if (valid) begin
                        state_d = (ARM_TARGET == ARM_W'(1)) ? LINK_UP : LINK_ARMING;
                        arm_d   = ARM_W'(1);
                    end
                end
                LINK_ARMING: begin
                    if (valid) begin
                        arm_d = arm_q + 1'b1;
                        if (arm_q + 1'b1 == ARM_TARGET) begin
                            state_d = LINK_UP;
                        end
                    end else if (invalid || expiry) begin
                        state_d = LINK_DOWN;
                        arm_d   = '0;
                    end
                end
                LINK_UP: begin
                    if (!valid && expiry) begin
                        state_d = LINK_DOWN;
                        arm_d   = '0;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        link_up_d = (state_q == LINK_UP);
        fault_d   = (state_q == LINK_FAULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a_q  <= '0;
            sync_b_q  <= '0;
            width_q   <= '0;
            gap_q     <= '0;
            flt_q     <= '0;
            arm_q     <= '0;
            count_q   <= '0;
            state_q   <= LINK_DOWN;
            link_up_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            sync_a_q  <= sync_a_d;
            sync_b_q  <= sync_b_d;
            width_q   <= width_d;
            gap_q     <= gap_d;
            flt_q     <= flt_d;
            arm_q     <= arm_d;
            count_q   <= count_d;
            state_q   <= state_d;
            link_up_q <= link_up_d;
            fault_q   <= fault_d;
        end
    end

    assign link_up     = link_up_q;
    assign pulse_count = count_q;
    assign pair_fault  = fault_q;

endmodule

// File: rtl/pair_link_monitor.sv
// Top level: two independent pair-set monitors (1236, 5478) and a registered
// combined link-up flag.
module pair_link_monitor
    import pair_link_monitor_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int PULSE_MIN    = 8,
    parameter int PULSE_MAX    = 24,
    parameter int GAP_MAX      = 1600000,
    parameter int LINK_PULSES  = 3,
    parameter int FAULT_CYCLES = 16
) (
    input  logic                Clock100MhzP,
    input  logic                Reset,
    pair_link_monitor_if.slave  bus
);

    logic                     link_up_1236, link_up_5478;
    logic                     fault_1236, fault_5478;
    logic [PULSE_COUNT_W-1:0] count_1236, count_5478;
    logic                     link_up_q, link_up_d;

    pair_pulse_fsm #(
        .SYNC_STAGES (SYNC_STAGES),
        .PULSE_MIN   (PULSE_MIN),
        .PULSE_MAX   (PULSE_MAX),
        .GAP_MAX     (GAP_MAX),
        .LINK_PULSES (LINK_PULSES),
        .FAULT_CYCLES(FAULT_CYCLES)
    ) u_pair_1236 (
        .clk        (Clock100MhzP),
        .rst        (Reset),
        .leg_a      (bus.TIA_568B12),
        .leg_b      (bus.TIA_568B36),
        .link_up    (link_up_1236),
        .pulse_count(count_1236),
        .pair_fault (fault_1236)
    );

    pair_pulse_fsm #(
        .SYNC_STAGES (SYNC_STAGES),
        .PULSE_MIN   (PULSE_MIN),
        .PULSE_MAX   (PULSE_MAX),
        .GAP_MAX     (GAP_MAX),
        .LINK_PULSES (LINK_PULSES),
        .FAULT_CYCLES(FAULT_CYCLES)
    ) u_pair_5478 (
        .clk        (Clock100MhzP),
        .rst        (Reset),
        .leg_a      (bus.TIA_568B54),
        .leg_b      (bus.TIA_568B78),
        .link_up    (link_up_5478),
        .pulse_count(count_5478),
        .pair_fault (fault_5478)
    );

    always_comb begin
        link_up_d = link_up_1236 & link_up_5478;
    end

    always_ff @(posedge Clock100MhzP) begin
        if (Reset) begin
            link_up_q <= 1'b0;
        end else begin
            link_up_q <= link_up_d;
        end
    end

    assign bus.LinkUp1236     = link_up_1236;
    assign bus.LinkUp5478     = link_up_5478;
    assign bus.LinkUp         = link_up_q;
    assign bus.PulseCount1236 = count_1236;
    assign bus.PulseCount5478 = count_5478;
    assign bus.PairFault1236  = fault_1236;
    assign bus.PairFault5478  = fault_5478;

endmodule

// File: tb/tb_pair_link_monitor.sv
// Directed bench for pair_link_monitor with shortened timing parameters.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_pair_link_monitor;

    localparam int SYNC_STAGES = 2;
    localparam int GAP_MAX     = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passed = 0;

    pair_link_monitor_if bus();

    pair_link_monitor #(
        .SYNC_STAGES (SYNC_STAGES),
        .PULSE_MIN   (4),
        .PULSE_MAX   (8),
        .GAP_MAX     (GAP_MAX),
        .LINK_PULSES (3),
        .FAULT_CYCLES(4)
    ) dut (
        .Clock100MhzP(clk),
        .Reset       (rst),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raise the selected A legs for w cycles, then hold everything low for low cycles.
    task automatic pulse(input bit on12, input bit on54, input int w, input int low);
        bus.TIA_568B12 = on12;
        bus.TIA_568B54 = on54;
        tick(w);
        bus.TIA_568B12 = 1'b0;
        bus.TIA_568B54 = 1'b0;
        tick(low);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        logic [20:0] all_out;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.TIA_568B12 = 1'($urandom_range(0, 1));
            bus.TIA_568B36 = 1'($urandom_range(0, 1));
            bus.TIA_568B54 = 1'($urandom_range(0, 1));
            bus.TIA_568B78 = 1'($urandom_range(0, 1));
            tick(1);
            all_out = {bus.LinkUp1236, bus.LinkUp5478, bus.LinkUp, bus.PairFault1236,
                       bus.PairFault5478, bus.PulseCount1236, bus.PulseCount5478};
            checks++;
            if (all_out !== 21'd0) $display("[TB] FAIL reset_hold%0d: outputs %h expected 0", i, all_out);
            else passed++;
        end
        bus.TIA_568B12 = 1'b0;
        bus.TIA_568B36 = 1'b0;
        bus.TIA_568B54 = 1'b0;
        bus.TIA_568B78 = 1'b0;
        rst = 1'b0;
        tick(1);
        all_out = {bus.LinkUp1236, bus.LinkUp5478, bus.LinkUp, bus.PairFault1236,
                   bus.PairFault5478, bus.PulseCount1236, bus.PulseCount5478};
        checks++;
        if (all_out !== 21'd0) $display("[TB] FAIL reset_release: outputs %h expected 0", all_out);
        else passed++;
        tick(5);
    endtask

    task automatic test_link_up();
        pulse(1'b1, 1'b0, 6, 34);
        pulse(1'b1, 1'b0, 6, 34);
        pulse(1'b1, 1'b0, 6, SYNC_STAGES + 1);
        checks++;
        if (bus.LinkUp1236 !== 1'b0) $display("[TB] FAIL up1236_early: got %b expected 0", bus.LinkUp1236);
        else passed++;
        tick(1);
        checks++;
        if (bus.LinkUp1236 !== 1'b1) $display("[TB] FAIL up1236_latency: got %b expected 1", bus.LinkUp1236);
        else passed++;
        checks++;
        if (bus.PulseCount1236 !== 8'd3) $display("[TB] FAIL count1236_three: got %0d expected 3", bus.PulseCount1236);
        else passed++;
        checks++;
        if (bus.LinkUp !== 1'b0) $display("[TB] FAIL linkup_one_pair: got %b expected 0", bus.LinkUp);
        else passed++;

        // Pulse 12 alongside 54 so pair-set 1236 stays up while 5478 arms.
        pulse(1'b1, 1'b1, 6, 34);
        pulse(1'b1, 1'b1, 6, 34);
        pulse(1'b1, 1'b1, 6, SYNC_STAGES + 1);
        checks++;
        if (bus.LinkUp5478 !== 1'b0) $display("[TB] FAIL up5478_early: got %b expected 0", bus.LinkUp5478);
        else passed++;
        tick(1);
        checks++;
        if ({bus.LinkUp5478, bus.LinkUp} !== 2'b10) $display("[TB] FAIL up5478_then_linkup: got %b expected 10", {bus.LinkUp5478, bus.LinkUp});
        else passed++;
        tick(1);
        checks++;
        if (bus.LinkUp !== 1'b1) $display("[TB] FAIL linkup_both: got %b expected 1", bus.LinkUp);
        else passed++;
        checks++;
        if ({bus.PulseCount1236, bus.PulseCount5478} !== {8'd6, 8'd3}) $display("[TB] FAIL counts_after_up: got %0d/%0d expected 6/3", bus.PulseCount1236, bus.PulseCount5478);
        else passed++;
    endtask

    task automatic test_fault();
        bus.TIA_568B54 = 1'b1;
        bus.TIA_568B78 = 1'b1;
        tick(6);
        checks++;
        if (bus.PairFault5478 !== 1'b0) $display("[TB] FAIL fault_early: got %b expected 0", bus.PairFault5478);
        else passed++;
        tick(1);
        checks++;
        if ({bus.PairFault5478, bus.LinkUp5478} !== 2'b10) $display("[TB] FAIL fault_enter: got fault,up=%b expected 10", {bus.PairFault5478, bus.LinkUp5478});
        else passed++;
        checks++;
        if ({bus.LinkUp1236, bus.PairFault1236} !== 2'b10) $display("[TB] FAIL pair_independent: got up,fault=%b expected 10", {bus.LinkUp1236, bus.PairFault1236});
        else passed++;

        // Drop 78 only: a valid-width pulse on 54 seen while in FAULT.
        bus.TIA_568B78 = 1'b0;
        tick(1);
        checks++;
        if (bus.LinkUp !== 1'b0) $display("[TB] FAIL linkup_on_fault: got %b expected 0", bus.LinkUp);
        else passed++;
        tick(5);
        bus.TIA_568B54 = 1'b0;
        tick(5);
        checks++;
        if ({bus.PairFault5478, bus.PulseCount5478} !== {1'b1, 8'd3}) $display("[TB] FAIL fault_ignores_pulse: got fault=%b count=%0d expected 1/3", bus.PairFault5478, bus.PulseCount5478);
        else passed++;
        tick(5);
        checks++;
        if ({bus.PairFault5478, bus.LinkUp5478} !== 2'b00) $display("[TB] FAIL fault_clear: got fault,up=%b expected 00", {bus.PairFault5478, bus.LinkUp5478});
        else passed++;
    endtask

    task automatic test_expiry();
        tick(80);
        checks++;
        if (bus.LinkUp1236 !== 1'b0) $display("[TB] FAIL idle_drop: got %b expected 0", bus.LinkUp1236);
        else passed++;
        pulse(1'b1, 1'b0, 6, 34);
        pulse(1'b1, 1'b0, 6, 34);
        // Timer reloads on the detect edge (fall+SYNC_STAGES+1), reaches GAP_MAX, then two more edges to the output.
        pulse(1'b1, 1'b0, 6, SYNC_STAGES + 1 + GAP_MAX + 1);
        checks++;
        if (bus.LinkUp1236 !== 1'b1) $display("[TB] FAIL expiry_before: got %b expected 1", bus.LinkUp1236);
        else passed++;
        tick(1);
        checks++;
        if (bus.LinkUp1236 !== 1'b0) $display("[TB] FAIL expiry_drop: got %b expected 0", bus.LinkUp1236);
        else passed++;
        checks++;
        if (bus.PulseCount1236 !== 8'd9) $display("[TB] FAIL expiry_count_held: got %0d expected 9", bus.PulseCount1236);
        else passed++;
    endtask

    task automatic test_arming_errors();
        int widths[2] = '{2, 12};
        logic [7:0] base;
        for (int k = 0; k < 2; k++) begin
            tick(80);
            base = bus.PulseCount1236;
            pulse(1'b1, 1'b0, 6, 34);
            pulse(1'b1, 1'b0, widths[k], 40 - widths[k]);
            checks++;
            if (bus.PulseCount1236 !== 8'(base + 8'd1)) $display("[TB] FAIL invalid_w%0d_count: got %0d expected %0d", widths[k], bus.PulseCount1236, base + 8'd1);
            else passed++;
            pulse(1'b1, 1'b0, 6, 34);
            pulse(1'b1, 1'b0, 6, 34);
            checks++;
            if (bus.LinkUp1236 !== 1'b0) $display("[TB] FAIL invalid_w%0d_rearm: got %b expected 0", widths[k], bus.LinkUp1236);
            else passed++;
            pulse(1'b1, 1'b0, 6, 34);
            checks++;
            if ({bus.LinkUp1236, bus.PulseCount1236} !== {1'b1, 8'(base + 8'd4)}) $display("[TB] FAIL invalid_w%0d_up: got up=%b count=%0d expected 1/%0d", widths[k], bus.LinkUp1236, bus.PulseCount1236, base + 8'd4);
            else passed++;
        end

        // Second fall lands in the cycle the gap timer reaches GAP_MAX.
        tick(80);
        pulse(1'b1, 1'b0, 6, GAP_MAX + 1 - 6);
        pulse(1'b1, 1'b0, 6, 34);
        pulse(1'b1, 1'b0, 6, 34);
        checks++;
        if ({bus.LinkUp1236, bus.PulseCount1236} !== {1'b1, 8'd20}) $display("[TB] FAIL pulse_beats_expiry: got up=%b count=%0d expected 1/20", bus.LinkUp1236, bus.PulseCount1236);
        else passed++;
    endtask

    task automatic test_reset_restart();
        tick(80);
        pulse(1'b1, 1'b0, 6, 34);
        pulse(1'b1, 1'b0, 6, 34);
        pulse_reset();
        checks++;
        if ({bus.PulseCount1236, bus.PulseCount5478, bus.LinkUp1236} !== 17'd0) $display("[TB] FAIL reset_mid_arm: got %0d/%0d up=%b expected 0/0/0", bus.PulseCount1236, bus.PulseCount5478, bus.LinkUp1236);
        else passed++;
        pulse(1'b1, 1'b0, 6, 34);
        pulse(1'b1, 1'b0, 6, 34);
        checks++;
        if (bus.LinkUp1236 !== 1'b0) $display("[TB] FAIL restart_two: got %b expected 0", bus.LinkUp1236);
        else passed++;
        pulse(1'b1, 1'b0, 6, 34);
        checks++;
        if ({bus.LinkUp1236, bus.PulseCount1236} !== {1'b1, 8'd3}) $display("[TB] FAIL restart_three: got up=%b count=%0d expected 1/3", bus.LinkUp1236, bus.PulseCount1236);
        else passed++;
    endtask

    task automatic test_wrap();
        pulse_reset();
        for (int i = 0; i < 255; i++) begin
            pulse(1'b1, 1'b0, 6, 6);
        end
        checks++;
        if (bus.PulseCount1236 !== 8'd255) $display("[TB] FAIL count_255: got %0d expected 255", bus.PulseCount1236);
        else passed++;
        pulse(1'b1, 1'b0, 6, 6);
        checks++;
        if ({bus.PulseCount1236, bus.LinkUp1236} !== {8'd0, 1'b1}) $display("[TB] FAIL count_wrap: got count=%0d up=%b expected 0/1", bus.PulseCount1236, bus.LinkUp1236);
        else passed++;
    endtask

    initial begin
        bus.TIA_568B12 = 1'b0;
        bus.TIA_568B36 = 1'b0;
        bus.TIA_568B54 = 1'b0;
        bus.TIA_568B78 = 1'b0;
        test_reset();
        test_link_up();
        test_fault();
        test_expiry();
        test_arming_errors();
        test_reset_restart();
        test_wrap();
        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
